// File: rtl/ctx_seq_pkg.sv
// Shared definitions for the context sequencer: entry mode codes, run state
// encoding and the width of one branch/control memory entry.
package ctx_seq_pkg;

  localparam logic [2:0] CTX_NEXT       = 3'b000;
  localparam logic [2:0] CTX_JREL       = 3'b001;
  localparam logic [2:0] CTX_JREL_NC    = 3'b010;
  localparam logic [2:0] CTX_JABS_NC    = 3'b011;
  localparam logic [2:0] CTX_JABS       = 3'b100;
  localparam logic [2:0] CTX_LOOP_BEGIN = 3'b101;
  localparam logic [2:0] CTX_LOOP_END   = 3'b110;
  localparam logic [2:0] CTX_HALT       = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ctx_state_t;

  // An entry is {mode[2:0], arg[addr_width-1:0]}.
  function automatic int entry_width(input int addr_width);
    return addr_width + 3;
  endfunction

endpackage

// File: rtl/ctx_loop_stack.sv
// LIFO of hardware-loop frames {start, remaining}; the top frame is the one
// selected by the current occupancy.
module ctx_loop_stack
  import ctx_seq_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          push,
  input  logic          pop,
  input  logic          dec,
  input  logic          clear,
  input  logic [AW-1:0] push_start,
  input  logic [AW-1:0] push_rem,
  output logic [AW-1:0] top_start,
  output logic [AW-1:0] top_rem,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [CW-1:0]                count_reg;
  logic [DEPTH-1:0][AW-1:0]     sel_start;
  logic [DEPTH-1:0][AW-1:0]     sel_rem;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [AW-1:0] start_reg;
      logic [AW-1:0] rem_reg;

      always_ff @(posedge CLK_I) begin
        if (push && count_reg == CW'(gi)) begin
          start_reg <= push_start;
          rem_reg   <= push_rem;
        end else if (dec && count_reg == CW'(gi + 1)) begin
          rem_reg <= rem_reg - AW'(1);
        end
      end

      // Only the slot just below the occupancy mark contributes to the top.
      assign sel_start[gi] = (count_reg == CW'(gi + 1)) ? start_reg : '0;
      assign sel_rem[gi]   = (count_reg == CW'(gi + 1)) ? rem_reg   : '0;
    end
  endgenerate

  always_comb begin
    top_start = '0;
    top_rem   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      top_start = top_start | sel_start[i];
      top_rem   = top_rem   | sel_rem[i];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I || clear) begin
      count_reg <= '0;
    end else if (push && !full) begin
      count_reg <= count_reg + CW'(1);
    end else if (pop && !empty) begin
      count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/context_sequencer.sv
// Context sequencer: branch/control memory plus run/halt FSM producing the
// registered context counter shared by every PE context memory.
module context_sequencer
  import ctx_seq_pkg::*;
#(
  parameter int CONTEXT_ADDR_WIDTH    = 8,
  parameter int CONTEXT_MEMORY_LENGTH = 256,
  parameter int LOOP_STACK_DEPTH      = 4,
  localparam int AW = CONTEXT_ADDR_WIDTH,
  localparam int EW = entry_width(CONTEXT_ADDR_WIDTH),
  localparam int DW = $clog2(LOOP_STACK_DEPTH + 1)
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          EN_I,
  input  logic          CBOX_I,
  input  logic [EW-1:0] DATA_I,
  input  logic          WR_EN_I,
  input  logic [AW-1:0] ADDR_I,
  input  logic          LOAD_EN_I,
  output logic [AW-1:0] CCNT_O,
  output logic          RUNNING_O,
  output logic          DONE_O,
  output logic          ERR_O,
  output logic [DW-1:0] LOOP_DEPTH_O
);

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [EW-1:0] mem [CONTEXT_MEMORY_LENGTH];
  logic [EW-1:0] entry_reg;
  ctx_state_t    state_reg, state_next;
  logic [AW-1:0] ccnt_reg, ccnt_next;
  logic          err_reg, err_next;
  logic          advance;

  logic [2:0]    mode;
  logic [AW-1:0] arg, ccnt_inc;
  logic          push, pop, dec, clear;
  logic [AW-1:0] push_rem, top_start, top_rem;
  logic          full, empty;

  assign mode     = entry_reg[EW-1 -: 3];
  assign arg      = entry_reg[AW-1:0];
  assign ccnt_inc = ccnt_reg + ADDR_ONE;
  assign push_rem = (arg == '0) ? ADDR_ONE : arg;

  ctx_loop_stack #(
    .AW    (AW),
    .DEPTH (LOOP_STACK_DEPTH)
  ) u_stack (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .push       (push),
    .pop        (pop),
    .dec        (dec),
    .clear      (clear),
    .push_start (ccnt_inc),
    .push_rem   (push_rem),
    .top_start  (top_start),
    .top_rem    (top_rem),
    .full       (full),
    .empty      (empty),
    .count      (LOOP_DEPTH_O)
  );

  always_comb begin
    state_next = state_reg;
    ccnt_next  = ccnt_reg;
    err_next   = err_reg;
    advance    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    dec        = 1'b0;
    clear      = 1'b0;
    if (EN_I) begin
      if (LOAD_EN_I) begin
        ccnt_next  = ADDR_I;
        clear      = 1'b1;
        err_next   = 1'b0;
        state_next = ST_RUN;
        advance    = 1'b1;
      end else if (state_reg == ST_RUN) begin
        advance   = 1'b1;
        ccnt_next = ccnt_inc;
        case (mode)
          CTX_JREL:       ccnt_next = ccnt_reg + arg;
          CTX_JREL_NC:    if (!CBOX_I) ccnt_next = ccnt_reg + arg;
          CTX_JABS_NC:    if (!CBOX_I) ccnt_next = arg;
          CTX_JABS:       ccnt_next = arg;
          CTX_LOOP_BEGIN: if (full) err_next = 1'b1; else push = 1'b1;
          CTX_LOOP_END: begin
            if (empty) begin
              err_next = 1'b1;
            end else if (top_rem > ADDR_ONE) begin
              dec       = 1'b1;
              ccnt_next = top_start;
            end else begin
              pop = 1'b1;
            end
          end
          CTX_HALT: begin
            // Halting keeps the counter and its fetched entry in place.
            advance    = 1'b0;
            ccnt_next  = ccnt_reg;
            state_next = ST_HALT;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_reg <= ST_IDLE;
      ccnt_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ccnt_reg  <= ccnt_next;
      err_reg   <= err_next;
    end
  end

  // Fetch alongside the counter update so entry_reg always matches CCNT_O;
  // a same-edge write to that address is seen only on the next fetch.
  always_ff @(posedge CLK_I) begin
    if (WR_EN_I) mem[ADDR_I] <= DATA_I;
    if (advance && !RST_I) entry_reg <= mem[ccnt_next];
  end

  assign CCNT_O    = ccnt_reg;
  assign RUNNING_O = (state_reg == ST_RUN);
  assign DONE_O    = (state_reg == ST_HALT);
  assign ERR_O     = err_reg;

endmodule

// File: doc/context_sequencer.md
Name: context_sequencer

Overview:
- Parametrised successor to the CGRA context control unit. Holds the branch/control memory and generates the context counter (CCNT_O) that addresses every PE context memory in lockstep.
- Adds registered CCNT_O, a run/halt state machine and an explicit mode field per entry: relative/absolute and conditional/unconditional jumps, halt, and nested hardware loops backed by a loop stack.
- Sits between the host load interface (ADDR_I/DATA_I) and the PE array's condition box (CBOX_I).

Parameters:
- CONTEXT_ADDR_WIDTH, 8: width of context address, jump target and loop count.
- CONTEXT_MEMORY_LENGTH, 256: number of entries, at most 2^CONTEXT_ADDR_WIDTH.
- LOOP_STACK_DEPTH, 4: maximum nesting of hardware loops, at least 1.

Ports:
- CLK_I  in  1  single clock, all state updates on rising edge.
- RST_I  in  1  reset, synchronous, active-high.
- EN_I  in  1  global enable; low = full stall (no state change except memory writes).
- CBOX_I  in  1  condition from condition box, sampled in the cycle it is used.
- DATA_I  in  CONTEXT_ADDR_WIDTH+3  entry to write, {mode[2:0], arg[CONTEXT_ADDR_WIDTH-1:0]}.
- WR_EN_I  in  1  write DATA_I to entry ADDR_I.
- ADDR_I  in  CONTEXT_ADDR_WIDTH  write address; also the start address when LOAD_EN_I is high.
- LOAD_EN_I  in  1  start or restart execution at ADDR_I.
- CCNT_O  out  CONTEXT_ADDR_WIDTH  current context, registered.
- RUNNING_O  out  1  state is RUN.
- DONE_O  out  1  state is HALT.
- ERR_O  out  1  sticky loop-stack error.
- LOOP_DEPTH_O  out  clog2(LOOP_STACK_DEPTH+1)  current stack occupancy.

Behaviour:
- Reset (RST_I=1 at an edge, overrides all other inputs):
  - CCNT_O=0, state IDLE, RUNNING_O=0, DONE_O=0, ERR_O=0, stack empty, LOOP_DEPTH_O=0.
  - Memory contents are not cleared.
  - Reset mid-RUN aborts immediately.
- Memory:
  - Synchronous write when WR_EN_I=1, independent of EN_I and state.
  - Synchronous read: at each advancing edge, CCNT_O<=nxt and entry_q<=mem[nxt], so entry_q always describes CCNT_O with zero bubbles.
  - Read-before-write on an address collision (entry_q gets the old data).
- States:
  - IDLE: CCNT_O holds.
  - RUN: advance every cycle EN_I=1.
  - HALT: CCNT_O holds, DONE_O=1.
  - LOAD_EN_I=1 with EN_I=1, from any state: nxt=ADDR_I, stack cleared, ERR_O cleared, state->RUN. Takes priority over the entry decode.
- Modes in RUN (c=CCNT_O, a=arg, all arithmetic modulo 2^CONTEXT_ADDR_WIDTH, wrap allowed):
  - 000 NEXT: nxt=c+1.
  - 001 JREL: nxt=c+a.
  - 010 JREL_NC: nxt = !CBOX_I ? c+a : c+1.
  - 011 JABS_NC: nxt = !CBOX_I ? a : c+1.
  - 100 JABS: nxt=a.
  - 101 LOOP_BEGIN: push {start=c+1, remaining=max(a,1)}; nxt=c+1. The body therefore runs max(a,1) times.
  - 110 LOOP_END: if top.remaining>1, decrement it and nxt=top.start; else pop and nxt=c+1.
  - 111 HALT: state->HALT, CCNT_O unchanged.
- Stack errors:
  - LOOP_BEGIN with a full stack: ERR_O<=1, no push, treated as NEXT.
  - LOOP_END with an empty stack: ERR_O<=1, treated as NEXT.
- EN_I=0: CCNT_O, entry_q, stack and state all frozen; a pending LOAD_EN_I is ignored.
- Writing the entry currently in entry_q does not affect it until it is re-fetched.

Decomposition:
- Shared package ctx_seq_pkg: mode localparams (CTX_NEXT .. CTX_HALT), state encoding (IDLE/RUN/HALT), entry-width function.
- Sub-module ctx_loop_stack: parametrised LIFO of {start, remaining} with push, pop, decrement-top, clear, full, empty and count.

Test Plan:
- Reset, write NEXT at 0..2 and HALT at 3, LOAD at 0 -> CCNT_O 0,1,2,3 on consecutive cycles, then DONE_O=1 and CCNT_O stays 3.
- Entry 5=JREL_NC a=-2 (0xFE), CBOX_I=0 -> CCNT_O 5->3; CBOX_I=1 -> 5->6; entry 7=JABS a=0x40 -> 7->0x40.
- LOOP_BEGIN a=3 at 10, NEXT at 11, LOOP_END at 12 -> CCNT_O 10,11,12,11,12,11,12,13; LOOP_DEPTH_O 0->1->0.
- LOOP_STACK_DEPTH=2 with three nested LOOP_BEGINs -> ERR_O=1 from the third, depth stays 2; a later LOAD_EN_I clears ERR_O.
- Hold EN_I=0 for 4 cycles mid-loop -> CCNT_O and LOOP_DEPTH_O frozen, sequence resumes unchanged; WR_EN_I during the stall still writes.
- Assert RST_I mid-loop with a pending LOAD -> next cycle CCNT_O=0, IDLE, depth 0; LOAD_EN_I in HALT restarts at ADDR_I.
